cg_iteration_sequencer: RTL

CG_ITERATION_SEQUENCER -- requirements
Module: cg_iteration_sequencer

---
 rtl/cg_pkg.sv | 42 ++++
 rtl/read_pulse_gen.sv | 64 ++++++
 rtl/cg_iteration_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cg_pkg.sv
// ============================================================================
// Module  : cg_pkg
// Purpose : Shared types and constants for the conjugate-gradient iteration
//           sequencer. Holds the sequencer state encoding, the default
//           datapath widths and the default convergence threshold on r.r.
//           Also provides a ceiling-division helper that sizes the
//           word-fetch bursts.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cg_pkg;

  localparam int unsigned c_no_of_units   = 8;
  localparam int unsigned c_element_width = 32;
  localparam int unsigned c_iter_width    = 16;
  localparam logic [31:0] c_tolerance     = 32'h283424DC;

  // Encoding is visible on the debug "state" port, so the values are fixed.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RR     = 4'd1,
    ST_MXV    = 4'd2,
    ST_ALPHA  = 4'd3,
    ST_UPDATE = 4'd4,
    ST_RNEW   = 4'd5,
    ST_CHECK  = 4'd6,
    ST_BETA   = 4'd7,
    ST_PUPD   = 4'd8,
    ST_DONE   = 4'd9
  } cg_state_e;

  // ceil(num/den) without forming num+den-1, so totals near 2^32 cannot wrap.
  function automatic logic [31:0] ceil_div(input logic [31:0] num,
                                           input logic [31:0] den);
    ceil_div = (num / den) + (((num % den) != 32'd0) ? 32'd1 : 32'd0);
  endfunction

endpackage : cg_pkg

`default_nettype wire

// File: rtl/read_pulse_gen.sv
// ============================================================================
// Module  : read_pulse_gen
// Purpose : Emits `count` single-cycle pulses, one cycle high then one cycle
//           low, starting the cycle after enable rises. done rises once all
//           pulses have been emitted. Dropping enable clears everything, so
//           each enable window starts a fresh burst.
// Ports   : clk, reset (async, active-high)
//           enable  in  1   burst window
//           count   in  32  number of pulses in the burst
//           pulse   out 1   registered pulse
//           done    out 1   burst complete (level, while enable stays high)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module read_pulse_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] count,
  output logic        pulse,
  output logic        done
);

  logic [31:0] cnt_q, cnt_d;
  logic        pulse_q, pulse_d;
  logic        done_q, done_d;

  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    done_d  = done_q;
    if (!enable) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (!pulse_q) begin
      // A high cycle is always followed by a forced low cycle.
      if (cnt_q < count) begin
        pulse_d = 1'b1;
        cnt_d   = cnt_q + 32'd1;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign pulse = pulse_q;
  assign done  = done_q;

endmodule : read_pulse_gen

`default_nettype wire

// File: rtl/cg_iteration_sequencer.sv
// ============================================================================
// Module  : cg_iteration_sequencer
// Purpose : Control FSM for one conjugate-gradient solve. Walks the stages
//           rsold -> A*p -> alpha -> x/r update -> rsnew -> convergence check
//           -> beta -> p update, handshaking with the datapath stages through
//           start/hold outputs and finish pulses, until r.r falls to
//           TOLERANCE or max_iter iterations are reached.
// Ports   : clk, reset (async, active-high), go (start pulse)
//           total (vector length), max_iter (iteration limit)
//           *_finish            stage-done pulses in
//           vxv1/vxv3_result    rsold / rsnew dot products in
//           reset_vxv1/mxv      stage holds out (high = held)
//           outsider_read(2)    rKold fetch pulses out
//           start_mul_add/vxv3  level enables; start_div2/mul_add3_start pulses
//           rold, rnew          latched dot products
//           iter_count, busy, finish_all, converged, state (debug)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cg_iteration_sequencer
  import cg_pkg::*;
#(
  parameter int          no_of_units   = c_no_of_units,
  parameter int          element_width = c_element_width,
  parameter int          iter_width    = c_iter_width,
  parameter logic [31:0] TOLERANCE     = c_tolerance
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [31:0]              total,
  input  logic [iter_width-1:0]    max_iter,
  input  logic                     vxv1_finish,
  input  logic                     mxv_finish,
  input  logic                     div1_finish,
  input  logic                     mul_add1_finish,
  input  logic                     mul_add2_finish,
  input  logic                     vxv3_finish,
  input  logic                     div2_finish,
  input  logic                     mul_add3_finish,
  input  logic [element_width-1:0] vxv1_result,
  input  logic [element_width-1:0] vxv3_result,
  output logic                     reset_vxv1,
  output logic                     reset_mxv,
  output logic                     outsider_read,
  output logic                     outsider_read2,
  output logic                     start_mul_add,
  output logic                     start_vxv3,
  output logic                     start_div2,
  output logic                     mul_add3_start,
  output logic [element_width-1:0] rold,
  output logic [element_width-1:0] rnew,
  output logic [iter_width-1:0]    iter_count,
  output logic                     busy,
  output logic                     finish_all,
  output logic                     converged,
  output logic [3:0]               state
);

  localparam logic [element_width-1:0] c_tol      = element_width'(TOLERANCE);
  localparam logic [iter_width-1:0]    c_iter_one = iter_width'(1);

  cg_state_e                state_q;
  logic                     reset_vxv1_q, reset_mxv_q;
  logic                     start_mul_add_q, start_vxv3_q;
  logic                     start_div2_q, mul_add3_start_q;
  logic [element_width-1:0] rold_q, rnew_q;
  logic [iter_width-1:0]    iter_count_q;
  logic                     busy_q, finish_all_q, converged_q;
  logic                     ma1_seen_q, ma2_seen_q;

  logic [31:0] n_reads;
  logic        short_vec;
  logic        ma1_any, ma2_any;
  logic        limit_hit;
  logic        rd1_done, rd2_done;
  logic        done_unused;

  assign n_reads   = ceil_div(total, 32'(no_of_units));
  assign short_vec = (total < 32'(no_of_units));
  // Sticky flags OR'd with the live pulses so a same-cycle pair completes.
  assign ma1_any   = ma1_seen_q | mul_add1_finish;
  assign ma2_any   = ma2_seen_q | mul_add2_finish;
  // Extra bit keeps the +1 from wrapping at a saturated count.
  assign limit_hit = (({1'b0, iter_count_q} + {{iter_width{1'b0}}, 1'b1})
                      >= {1'b0, max_iter});
  assign done_unused = rd1_done ^ rd2_done;

  read_pulse_gen u_rd1_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ST_RR),
    .count  (n_reads),
    .pulse  (outsider_read),
    .done   (rd1_done)
  );

  read_pulse_gen u_rd2_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ST_RNEW),
    .count  (n_reads),
    .pulse  (outsider_read2),
    .done   (rd2_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      reset_vxv1_q     <= 1'b1;
      reset_mxv_q      <= 1'b1;
      start_mul_add_q  <= 1'b0;
      start_vxv3_q     <= 1'b0;
      start_div2_q     <= 1'b0;
      mul_add3_start_q <= 1'b0;
      rold_q           <= '0;
      rnew_q           <= '0;
      iter_count_q     <= '0;
      busy_q           <= 1'b0;
      finish_all_q     <= 1'b0;
      converged_q      <= 1'b0;
      ma1_seen_q       <= 1'b0;
      ma2_seen_q       <= 1'b0;
    end else begin
      start_div2_q     <= 1'b0;
      mul_add3_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            iter_count_q <= '0;
            converged_q  <= 1'b0;
            if (short_vec) begin
              state_q      <= ST_DONE;
              finish_all_q <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              state_q      <= ST_RR;
              finish_all_q <= 1'b0;
              busy_q       <= 1'b1;
              reset_vxv1_q <= 1'b0;
            end
          end
        end
        ST_RR: begin
          if (vxv1_finish) begin
            rold_q       <= vxv1_result;
            reset_vxv1_q <= 1'b1;
            reset_mxv_q  <= 1'b0;
            state_q      <= ST_MXV;
          end
        end
        ST_MXV: begin
          if (mxv_finish) begin
            reset_mxv_q <= 1'b1;
            state_q     <= ST_ALPHA;
          end
        end
        ST_ALPHA: begin
          if (div1_finish) begin
            start_mul_add_q <= 1'b1;
            ma1_seen_q      <= 1'b0;
            ma2_seen_q      <= 1'b0;
            state_q         <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (ma1_any && ma2_any) begin
            start_mul_add_q <= 1'b0;
            ma1_seen_q      <= 1'b0;
            ma2_seen_q      <= 1'b0;
            start_vxv3_q    <= 1'b1;
            state_q         <= ST_RNEW;
          end else begin
            ma1_seen_q <= ma1_any;
            ma2_seen_q <= ma2_any;
          end
        end
        ST_RNEW: begin
          if (vxv3_finish) begin
            rnew_q       <= vxv3_result;
            start_vxv3_q <= 1'b0;
            state_q      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (rnew_q <= c_tol) begin
            converged_q  <= 1'b1;
            finish_all_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_DONE;
          end else if (limit_hit) begin
            converged_q  <= 1'b0;
            finish_all_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_DONE;
          end else begin
            start_div2_q <= 1'b1;
            state_q      <= ST_BETA;
          end
        end
        ST_BETA: begin
          if (div2_finish) begin
            mul_add3_start_q <= 1'b1;
            state_q          <= ST_PUPD;
          end
        end
        ST_PUPD: begin
          // Both holds are already high here, so the datapath sees at least
          // this cycle of hold before the next RR pass releases vXv1.
          if (mul_add3_finish) begin
            if (iter_count_q != '1) begin
              iter_count_q <= iter_count_q + c_iter_one;
            end
            reset_vxv1_q <= 1'b0;
            state_q      <= ST_RR;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign reset_vxv1     = reset_vxv1_q;
  assign reset_mxv      = reset_mxv_q;
  assign start_mul_add  = start_mul_add_q;
  assign start_vxv3     = start_vxv3_q;
  assign start_div2     = start_div2_q;
  assign mul_add3_start = mul_add3_start_q;
  assign rold           = rold_q;
  assign rnew           = rnew_q;
  assign iter_count     = iter_count_q;
  assign busy           = busy_q;
  assign finish_all     = finish_all_q;
  assign converged      = converged_q;
  assign state          = state_q;

endmodule : cg_iteration_sequencer

`default_nettype wire
